// File: rtl/mac_frame_enc.sv
// TX frame encoder: serialises a 14-byte header and its payload into the PHY-TX byte FIFO,
// pads short frames up to MIN_PAYLOAD, truncates long ones at MAX_PAYLOAD and marks the last byte.
module mac_frame_enc #(
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic [111:0]   h_fifo_dout,
    input  logic           h_fifo_empty,
    output logic           h_fifo_rden,
    input  logic [7:0]     b_fifo_dout,
    input  logic           b_fifo_last,
    input  logic           b_fifo_empty,
    output logic           b_fifo_rden,
    output logic [7:0]     o_fifo_din,
    output logic           o_fifo_wren,
    output logic           o_fifo_del,
    input  logic           o_fifo_afull,
    output logic           frame_done
);

    localparam logic [10:0] MIN_C = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_C = 11'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PAD,
        S_DRAIN,
        S_END
    } state_t;

    state_t         state, state_nxt;
    logic [111:0]   hdr_q, hdr_nxt;
    logic [3:0]     byte_cnt, byte_cnt_nxt;
    logic [10:0]    pay_cnt, pay_cnt_nxt, pay_inc;
    logic [7:0]     din_nxt;
    logic           wren_nxt, del_nxt;

    assign pay_inc = pay_cnt + 11'd1;

    // Valid/ready: a FIFO word moves only in a cycle where rden is high and empty is low;
    // the corresponding output write is registered and appears on the following cycle.
    always_comb begin
        state_nxt    = state;
        hdr_nxt      = hdr_q;
        byte_cnt_nxt = byte_cnt;
        pay_cnt_nxt  = pay_cnt;
        din_nxt      = 8'h00;
        wren_nxt     = 1'b0;
        del_nxt      = 1'b0;
        h_fifo_rden  = 1'b0;
        b_fifo_rden  = 1'b0;
        case (state)
            S_IDLE: begin
                // Room for a whole maximum frame is checked once here, never per byte.
                if (!h_fifo_empty && !o_fifo_afull) begin
                    h_fifo_rden  = 1'b1;
                    hdr_nxt      = h_fifo_dout;
                    byte_cnt_nxt = 4'd0;
                    state_nxt    = S_HEADER;
                end
            end
            S_HEADER: begin
                din_nxt      = hdr_q[111:104];
                wren_nxt     = 1'b1;
                hdr_nxt      = {hdr_q[103:0], 8'h00};
                byte_cnt_nxt = byte_cnt + 4'd1;
                if (byte_cnt == 4'd13) begin
                    state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                b_fifo_rden = !b_fifo_empty;
                if (!b_fifo_empty) begin
                    din_nxt     = b_fifo_dout;
                    wren_nxt    = 1'b1;
                    pay_cnt_nxt = pay_inc;
                    if (b_fifo_last) begin
                        if (pay_inc >= MIN_C) begin
                            del_nxt   = 1'b1;
                            state_nxt = S_END;
                        end else begin
                            state_nxt = S_PAD;
                        end
                    end else if (pay_inc == MAX_C) begin
                        del_nxt   = 1'b1;
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_PAD: begin
                din_nxt     = PAD_BYTE;
                wren_nxt    = 1'b1;
                pay_cnt_nxt = pay_inc;
                if (pay_inc >= MIN_C) begin
                    del_nxt   = 1'b1;
                    state_nxt = S_END;
                end
            end
            S_DRAIN: begin
                // Oversized frame: discard the rest of its payload without writing.
                b_fifo_rden = !b_fifo_empty;
                if (!b_fifo_empty && b_fifo_last) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                hdr_nxt      = '0;
                byte_cnt_nxt = 4'd0;
                pay_cnt_nxt  = 11'd0;
                state_nxt    = S_IDLE;
            end
            default: begin
                state_nxt = S_END;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            hdr_q       <= '0;
            byte_cnt    <= 4'd0;
            pay_cnt     <= 11'd0;
            o_fifo_din  <= 8'h00;
            o_fifo_wren <= 1'b0;
            o_fifo_del  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            hdr_q       <= hdr_nxt;
            byte_cnt    <= byte_cnt_nxt;
            pay_cnt     <= pay_cnt_nxt;
            o_fifo_din  <= din_nxt;
            o_fifo_wren <= wren_nxt;
            o_fifo_del  <= del_nxt;
            frame_done  <= del_nxt;
        end
    end

endmodule

// File: tb/tb_mac_frame_enc.sv
// Bench for mac_frame_enc: FWFT FIFO models feed the DUT, a byte-level frame model fills exp_q,
// and every written byte is compared against it.
module tb_mac_frame_enc;

    localparam int         MIN_PAYLOAD = 46;
    localparam int         MAX_PAYLOAD = 1500;
    localparam logic [7:0] PAD         = 8'h00;
    localparam logic [111:0] HDR       = 112'h001122334455_66778899AABB_0800;

    logic           clk;
    logic           arst_n;
    logic [111:0]   h_fifo_dout;
    logic           h_fifo_empty;
    logic           h_fifo_rden;
    logic [7:0]     b_fifo_dout;
    logic           b_fifo_last;
    logic           b_fifo_empty;
    logic           b_fifo_rden;
    logic [7:0]     o_fifo_din;
    logic           o_fifo_wren;
    logic           o_fifo_del;
    logic           o_fifo_afull;
    logic           frame_done;

    mac_frame_enc #(
        .MIN_PAYLOAD (MIN_PAYLOAD),
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .PAD_BYTE    (PAD)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .h_fifo_dout  (h_fifo_dout),
        .h_fifo_empty (h_fifo_empty),
        .h_fifo_rden  (h_fifo_rden),
        .b_fifo_dout  (b_fifo_dout),
        .b_fifo_last  (b_fifo_last),
        .b_fifo_empty (b_fifo_empty),
        .b_fifo_rden  (b_fifo_rden),
        .o_fifo_din   (o_fifo_din),
        .o_fifo_wren  (o_fifo_wren),
        .o_fifo_del   (o_fifo_del),
        .o_fifo_afull (o_fifo_afull),
        .frame_done   (frame_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FIFO models; flushed by the same reset as the DUT
    logic [111:0] h_mem [0:15];
    logic [8:0]   b_mem [0:4095];
    int h_wr, h_rd, b_wr, b_rd;

    assign h_fifo_empty = (h_wr == h_rd);
    assign h_fifo_dout  = h_mem[h_rd[3:0]];
    assign b_fifo_empty = (b_wr == b_rd);
    assign b_fifo_dout  = b_mem[b_rd[11:0]][7:0];
    assign b_fifo_last  = b_mem[b_rd[11:0]][8];

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            h_rd <= h_wr;
            b_rd <= b_wr;
        end else begin
            if (h_fifo_rden && !h_fifo_empty) h_rd <= h_rd + 1;
            if (b_fifo_rden && !b_fifo_empty) b_rd <= b_rd + 1;
        end
    end

    // output monitor, sampled on the falling edge
    logic [8:0] obs_mem [0:16383];
    int obs_n, del_n, done_n, hpop_n, bad_done_n;

    always @(negedge clk) begin
        if (o_fifo_wren) begin
            obs_mem[obs_n[13:0]] <= {o_fifo_del, o_fifo_din};
            obs_n <= obs_n + 1;
            if (o_fifo_del) del_n <= del_n + 1;
        end
        if (frame_done) done_n <= done_n + 1;
        if (frame_done !== (o_fifo_wren && o_fifo_del)) bad_done_n <= bad_done_n + 1;
        if (h_fifo_rden) hpop_n <= hpop_n + 1;
    end

    // scoreboard
    logic [8:0] exp_q[$];
    logic [8:0] stage_q[$];
    int total, bad, pend;
    int chk_base, del_base, done_base, hpop_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [111:0] rand_hdr();
        return {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    endfunction

    // Reference frame: 14 header bytes MSB first, up to MAX_PAYLOAD payload bytes,
    // pad bytes up to MIN_PAYLOAD, end-of-frame flag on the final byte.
    task automatic push_frame(input logic [111:0] hdr, input int len, input bit ramp, input bit stage);
        logic [7:0] d;
        logic [8:0] e;
        h_mem[h_wr[3:0]] = hdr;
        h_wr = h_wr + 1;
        for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, hdr[111-8*i -: 8]});
        for (int i = 0; i < len; i++) begin
            d = ramp ? 8'(i) : 8'($urandom());
            e = {(i == len - 1), d};
            if (stage) begin
                stage_q.push_back(e);
            end else begin
                b_mem[b_wr[11:0]] = e;
                b_wr = b_wr + 1;
            end
            if (i < MAX_PAYLOAD) exp_q.push_back({1'b0, d});
        end
        for (int i = len; i < MIN_PAYLOAD; i++) exp_q.push_back({1'b0, PAD});
        exp_q[exp_q.size()-1][8] = 1'b1;
        pend++;
    endtask

    task automatic rebase();
        chk_base  = obs_n;
        del_base  = del_n;
        done_base = done_n;
        hpop_base = hpop_n;
        exp_q.delete();
        pend = 0;
    endtask

    task automatic check_frames(input string tag);
        int t, got_n, nerr, first;
        t = 0;
        while ((obs_n - chk_base) < exp_q.size() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (30) @(negedge clk);
        got_n = obs_n - chk_base;
        chk({tag, "_len"}, got_n, exp_q.size());
        nerr = 0;
        first = -1;
        for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
            logic [13:0] idx;
            idx = 14'(chk_base + i);
            if (obs_mem[idx] !== exp_q[i]) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        if (nerr != 0) $display("  %s first byte error at index %0d", tag, first);
        chk({tag, "_byte_errors"}, nerr, 0);
        chk({tag, "_del_count"}, del_n - del_base, pend);
        chk({tag, "_done_count"}, done_n - done_base, pend);
        chk({tag, "_hdr_pops"}, hpop_n - hpop_base, pend);
        chk({tag, "_body_drained"}, (b_rd == b_wr) ? 1 : 0, 1);
        chk({tag, "_done_with_del"}, bad_done_n, 0);
        rebase();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n0, h0, nerr;
        arst_n       = 1'b0;
        o_fifo_afull = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wren", o_fifo_wren, 0);
        chk("rst_del", o_fifo_del, 0);
        chk("rst_din", o_fifo_din, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_hrden", h_fifo_rden, 0);
        chk("rst_brden", b_fifo_rden, 0);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_wren", o_fifo_wren, 0);
        rebase();

        // 64-byte ramp payload: 78 writes
        push_frame(HDR, 64, 1'b1, 1'b0);
        check_frames("t1_64B");

        // short payload padded to minimum
        push_frame(HDR, 10, 1'b0, 1'b0);
        check_frames("t2_10B_pad");

        // oversized payload truncated, followed back-to-back by a normal frame
        push_frame(rand_hdr(), 1600, 1'b0, 1'b0);
        push_frame(rand_hdr(), 30, 1'b0, 1'b0);
        check_frames("t3_1600B_then_30B");

        // boundaries around MIN and MAX
        push_frame(rand_hdr(), MIN_PAYLOAD, 1'b0, 1'b0);
        check_frames("t4_min");
        push_frame(rand_hdr(), MIN_PAYLOAD - 1, 1'b0, 1'b0);
        check_frames("t4_min_m1");
        push_frame(rand_hdr(), MAX_PAYLOAD, 1'b0, 1'b0);
        check_frames("t4_max");
        push_frame(rand_hdr(), MAX_PAYLOAD + 1, 1'b0, 1'b0);
        check_frames("t4_max_p1");
        push_frame(rand_hdr(), 1, 1'b0, 1'b0);
        check_frames("t4_one_byte");

        // PHY-TX FIFO almost full holds the header pop
        o_fifo_afull = 1'b1;
        push_frame(rand_hdr(), 20, 1'b1, 1'b0);
        h0 = hpop_n;
        repeat (20) @(negedge clk);
        chk("t5_afull_hrden", hpop_n - h0, 0);
        chk("t5_afull_wren", obs_n - chk_base, 0);
        o_fifo_afull = 1'b0;
        check_frames("t5_afull");

        // body FIFO starves for 5 clk after every 8 bytes
        push_frame(rand_hdr(), 50, 1'b0, 1'b1);
        while (stage_q.size() > 0) begin
            for (int k = 0; k < 8 && stage_q.size() > 0; k++) begin
                b_mem[b_wr[11:0]] = stage_q.pop_front();
                b_wr = b_wr + 1;
            end
            t = 0;
            while (b_rd != b_wr && t < 300) begin
                @(negedge clk);
                t++;
            end
            chk("t5_chunk_drained", (b_rd == b_wr) ? 1 : 0, 1);
            @(negedge clk);
            n0 = obs_n;
            repeat (5) @(negedge clk);
            chk("t5_gap_no_wren", obs_n - n0, 0);
        end
        check_frames("t5_stall");

        // random lengths, single and back-to-back
        for (int k = 0; k < 6; k++) begin
            push_frame(rand_hdr(), $urandom_range(1, 140), 1'b0, 1'b0);
            check_frames("rnd_single");
        end
        for (int k = 0; k < 3; k++) push_frame(rand_hdr(), $urandom_range(1, 100), 1'b0, 1'b0);
        check_frames("rnd_burst");

        // reset in the middle of the payload
        push_frame(HDR, 64, 1'b1, 1'b0);
        t = 0;
        while ((obs_n - chk_base) < 34 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("t6_reached_byte20", ((obs_n - chk_base) >= 34) ? 1 : 0, 1);
        #1;
        arst_n = 1'b0;
        #1;
        chk("t6_async_wren", o_fifo_wren, 0);
        chk("t6_async_del", o_fifo_del, 0);
        chk("t6_async_din", o_fifo_din, 0);
        chk("t6_async_done", frame_done, 0);
        chk("t6_async_brden", b_fifo_rden, 0);
        @(posedge clk);
        #1;
        chk("t6_clk_wren", o_fifo_wren, 0);
        chk("t6_clk_hrden", h_fifo_rden, 0);
        nerr = 0;
        for (int i = 0; i < 34; i++) begin
            logic [13:0] idx;
            idx = 14'(chk_base + i);
            if (obs_mem[idx] !== exp_q[i]) nerr++;
        end
        chk("t6_partial_prefix", nerr, 0);
        chk("t6_no_del", del_n - del_base, 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        rebase();
        @(negedge clk);
        push_frame(HDR, 64, 1'b1, 1'b0);
        check_frames("t6_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
